// File: rtl/lpm_fifo_dc_flagctl_pkg.sv
// Shared definitions for the dual-clock FIFO flag controller: empty-state
// machine encodings, mode/checking string constants and a threshold helper.
package lpm_fifo_dc_flagctl_pkg;

  // One encoding space shared by both modes. READ mode uses EMPTY,
  // NON_EMPTY and EMPTY_WAIT; WRITE mode uses EMPTY, ONE and NON_EMPTY_W.
  typedef enum logic [1:0] {
    ST_EMPTY       = 2'b00,
    ST_NON_EMPTY   = 2'b01,
    ST_EMPTY_WAIT  = 2'b10,
    ST_NON_EMPTY_W = 2'b11
  } state_e;

  // WRITE-mode "one word just written" state reuses the 01 code
  localparam state_e ST_ONE = ST_NON_EMPTY;

  localparam string MODE_READ  = "READ";
  localparam string MODE_WRITE = "WRITE";
  localparam string CHK_ON     = "ON";
  localparam string CHK_OFF    = "OFF";

  // a - b, floored at zero (used for the full threshold)
  function automatic int unsigned floor_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/lpm_fifo_dc_emptysm.sv
// Empty-tracking state machine for one side of a dual-clock FIFO.
// READ mode predicts emptiness from the local word count and read history;
// WRITE mode tracks recent writes so empty drops on the first write edge.
module lpm_fifo_dc_emptysm
  import lpm_fifo_dc_flagctl_pkg::*;
#(
  parameter int lpm_widthad = 4,
  parameter bit write_mode  = 1'b0
) (
  input  logic                   clock,
  input  logic                   aclr,
  input  logic [lpm_widthad-1:0] usedw_i,
  input  logic                   wreq_i,
  input  logic                   rreq_i,
  input  logic                   valid_rreq_i,
  output logic                   empty_o,
  output state_e                 state_o
);

  state_e      state_q, state_d;
  logic        lrreq_q;
  logic        empty_q, empty_d;
  logic [31:0] usedw_ext;

  assign usedw_ext = 32'(usedw_i);

  // Next-state selection; empty follows the next state so both update together
  always_comb begin
    state_d = state_q;
    if (write_mode) begin
      case (state_q)
        ST_EMPTY:       if (wreq_i) state_d = ST_ONE;
        ST_ONE:         if (!wreq_i) state_d = ST_NON_EMPTY_W;
        ST_NON_EMPTY_W: begin
          if (wreq_i)                state_d = ST_ONE;
          else if (usedw_ext == 32'd0) state_d = ST_EMPTY;
        end
        default:        state_d = ST_EMPTY;
      endcase
    end else begin
      case (state_q)
        ST_EMPTY:      if (usedw_ext != 32'd0) state_d = ST_NON_EMPTY;
        // The last word is being read: either one word left with no read in
        // flight, or two left with the previous read not yet reflected.
        ST_NON_EMPTY:  if (rreq_i && (((usedw_ext == 32'd1) && !lrreq_q) ||
                                      ((usedw_ext == 32'd2) &&  lrreq_q)))
                         state_d = ST_EMPTY_WAIT;
        ST_EMPTY_WAIT: state_d = (usedw_ext > 32'd1) ? ST_NON_EMPTY : ST_EMPTY;
        default:       state_d = ST_EMPTY;
      endcase
    end
    empty_d = (state_d == ST_EMPTY) || (state_d == ST_EMPTY_WAIT);
  end

  // State, delayed accepted read and registered empty flag
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q <= ST_EMPTY;
      lrreq_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      lrreq_q <= valid_rreq_i;
      empty_q <= empty_d;
    end
  end

  assign empty_o = empty_q;
  assign state_o = state_q;

endmodule

// File: rtl/lpm_fifo_dc_flagctl.sv
// Flag controller for one clock domain of a dual-clock FIFO: registered
// empty/full/almost flags, request gating and sticky overflow/underflow.
module lpm_fifo_dc_flagctl
  import lpm_fifo_dc_flagctl_pkg::*;
#(
  parameter int    lpm_widthad        = 4,
  parameter int    lpm_numwords       = 16,
  parameter string lpm_mode           = "READ",
  parameter string underflow_checking = "ON",
  parameter string overflow_checking  = "ON",
  parameter int    full_margin        = 3,
  parameter int    almost_full_value  = 12,
  parameter int    almost_empty_value = 4
) (
  input  logic                   clock,
  input  logic                   aclr,
  input  logic [lpm_widthad-1:0] usedw_in,
  input  logic                   wreq,
  input  logic                   rreq,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic                   valid_rreq,
  output logic                   valid_wreq,
  output logic                   underflow,
  output logic                   overflow
);

  localparam bit IS_WRITE = (lpm_mode == MODE_WRITE);
  localparam bit MODE_OK  = (lpm_mode == MODE_READ) || (lpm_mode == MODE_WRITE);
  localparam bit UF_OK    = (underflow_checking == CHK_ON) || (underflow_checking == CHK_OFF);
  localparam bit OF_OK    = (overflow_checking == CHK_ON) || (overflow_checking == CHK_OFF);
  localparam bit THR_OK   = (almost_empty_value <= almost_full_value);
  localparam bit UF_CHK   = (underflow_checking == CHK_ON);
  localparam bit OF_CHK   = (overflow_checking == CHK_ON);

  localparam logic [31:0] FULL_THR = 32'(floor_sub(lpm_numwords, full_margin));
  localparam logic [31:0] AF_THR   = 32'(almost_full_value);
  localparam logic [31:0] AE_THR   = 32'(almost_empty_value);
  // Out-of-range thresholds pin the flag instead of comparing
  localparam bit AF_EN    = (almost_full_value <= lpm_numwords);
  localparam bit AE_FORCE = (almost_empty_value > lpm_numwords);

  if (!(MODE_OK && UF_OK && OF_OK && THR_OK)) begin : g_cfg_err
    $error("lpm_fifo_dc_flagctl: illegal configuration (lpm_mode, checking value, or almost_empty_value > almost_full_value)");
  end

  logic        full_q, full_d;
  logic        afull_q, afull_d;
  logic        aempty_q, aempty_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic        empty_w;
  logic [31:0] usedw_ext;
  state_e      state_w;

  assign usedw_ext = 32'(usedw_in);

  // Request gating against the currently registered flags
  assign valid_rreq = UF_CHK ? (rreq & ~empty_w) : rreq;
  assign valid_wreq = OF_CHK ? (wreq & ~full_q)  : wreq;

  lpm_fifo_dc_emptysm #(
    .lpm_widthad (lpm_widthad),
    .write_mode  (IS_WRITE)
  ) u_sm (
    .clock        (clock),
    .aclr         (aclr),
    .usedw_i      (usedw_in),
    .wreq_i       (wreq),
    .rreq_i       (rreq),
    .valid_rreq_i (valid_rreq),
    .empty_o      (empty_w),
    .state_o      (state_w)
  );

  // Threshold flags from the current count; error flags accumulate on
  // raw requests against the registered flags, independent of gating.
  always_comb begin
    full_d   = (usedw_ext >= FULL_THR);
    afull_d  = AF_EN && (usedw_ext >= AF_THR);
    aempty_d = AE_FORCE || (usedw_ext < AE_THR);
    ovf_d    = ovf_q | (wreq & full_q);
    udf_d    = udf_q | (rreq & empty_w);
  end

  // Flag registers, cleared asynchronously to their idle values
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign empty        = empty_w;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_lpm_fifo_dc_flagctl.sv
// Directed bench for lpm_fifo_dc_flagctl: a READ-mode instance for flags,
// gating and sticky errors, and a WRITE-mode instance for its state walk.
module tb_lpm_fifo_dc_flagctl;

  logic       clock = 1'b0;
  logic       aclr, aclr_w;
  logic [3:0] usedw, usedw_w;
  logic       wreq, rreq, wreq_w, rreq_w;
  logic       empty, full, almost_empty, almost_full;
  logic       valid_rreq, valid_wreq, underflow, overflow;
  logic       empty_w, full_w, ae_w, af_w, vr_w, vw_w, uf_w, of_w;
  logic [1:0] st_r, st_w;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    string      tag;
    logic [5:0] want;
    bit         wside;
  } exp_t;
  exp_t sbq[$];

  always #5 clock = ~clock;

  lpm_fifo_dc_flagctl dut (
    .clock(clock), .aclr(aclr), .usedw_in(usedw), .wreq(wreq), .rreq(rreq),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .valid_rreq(valid_rreq), .valid_wreq(valid_wreq),
    .underflow(underflow), .overflow(overflow)
  );

  lpm_fifo_dc_flagctl #(.lpm_mode("WRITE")) dut_w (
    .clock(clock), .aclr(aclr_w), .usedw_in(usedw_w), .wreq(wreq_w), .rreq(rreq_w),
    .empty(empty_w), .full(full_w), .almost_empty(ae_w), .almost_full(af_w),
    .valid_rreq(vr_w), .valid_wreq(vw_w),
    .underflow(uf_w), .overflow(of_w)
  );

  assign st_r = dut.u_sm.state_q;
  assign st_w = dut_w.u_sm.state_q;

  function automatic logic [5:0] rd_obs();
    return {empty, almost_empty, full, almost_full, underflow, overflow};
  endfunction

  function automatic logic [5:0] wr_obs();
    return {3'b000, empty_w, st_w};
  endfunction

  // Reference threshold model for default parameters (16 words, margin 3)
  function automatic logic [5:0] ramp_exp(input int u);
    return {(u == 0), (u < 4), (u >= 13), (u >= 12), 1'b1, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] want);
    nvec++;
    assert (obs === want) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  task automatic tick(input string tag, input logic [5:0] want, input bit wside);
    exp_t e;
    e.tag = tag; e.want = want; e.wside = wside;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    check(e.tag, e.wside ? wr_obs() : rd_obs(), e.want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aclr = 1'b1; aclr_w = 1'b1;
    usedw = 4'd0; wreq = 1'b0; rreq = 1'b0;
    usedw_w = 4'd0; wreq_w = 1'b0; rreq_w = 1'b0;
    #1;
    check("reset", rd_obs(), 6'b110000);

    // full/almost_full stay low under reset even with a full count
    usedw = 4'd15; wreq = 1'b1;
    @(posedge clock); #1;
    check("full_held_in_aclr", rd_obs(), 6'b110000);

    // Empty FIFO with reads pending
    aclr = 1'b0; usedw = 4'd0; wreq = 1'b0; rreq = 1'b1;
    #1;
    check("vrreq_when_empty", {5'b0, valid_rreq}, 6'd0);
    tick("uf_edge1", 6'b110010, 1'b0);
    tick("uf_edge2", 6'b110010, 1'b0);
    tick("uf_edge3", 6'b110010, 1'b0);

    // One word arrives, then it is read
    rreq = 1'b0; usedw = 4'd1;
    tick("ne_after_usedw1", 6'b010010, 1'b0);
    rreq = 1'b1;
    #1;
    check("vrreq_nonempty", {5'b0, valid_rreq}, 6'd1);
    tick("empty_at_rreq", 6'b110010, 1'b0);
    check("state_empty_wait", {4'b0, st_r}, 6'd2);
    rreq = 1'b0; usedw = 4'd0;
    tick("empty_final", 6'b110010, 1'b0);
    check("state_empty", {4'b0, st_r}, 6'd0);

    // Count ramp: flags follow one clock behind
    for (int u = 0; u < 16; u++) begin
      usedw = 4'(u);
      #1;
      if (u > 0) check($sformatf("ramp_pre_%0d", u), rd_obs(), ramp_exp(u - 1));
      tick($sformatf("ramp_%0d", u), ramp_exp(u), 1'b0);
    end

    // Write into a full FIFO
    wreq = 1'b1;
    #1;
    check("vwreq_when_full", {5'b0, valid_wreq}, 6'd0);
    tick("overflow_set", 6'b001111, 1'b0);
    wreq = 1'b0;
    tick("overflow_sticky", 6'b001111, 1'b0);

    // Asynchronous clear mid-stream
    #2 aclr = 1'b1;
    #1;
    check("async_clear", rd_obs(), 6'b110000);
    check("async_state", {4'b0, st_r}, 6'd0);
    tick("aclr_hold_full", 6'b110000, 1'b0);
    aclr = 1'b0;
    tick("first_edge_after_aclr", 6'b001100, 1'b0);

    // WRITE-mode state walk
    aclr_w = 1'b0; usedw_w = 4'd0; wreq_w = 1'b0;
    tick("w_c0", 6'b000100, 1'b1);
    wreq_w = 1'b1;
    tick("w_c1_one", 6'b000001, 1'b1);
    wreq_w = 1'b0; usedw_w = 4'd1;
    tick("w_c2_nonempty", 6'b000011, 1'b1);
    wreq_w = 1'b1;
    tick("w_c3_one", 6'b000001, 1'b1);
    wreq_w = 1'b0; usedw_w = 4'd2;
    tick("w_c4_nonempty", 6'b000011, 1'b1);
    tick("w_c5_hold", 6'b000011, 1'b1);
    usedw_w = 4'd0;
    tick("w_c6_empty", 6'b000100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lpm_fifo_dc_flagctl.md
LPM_FIFO_DC_FLAGCTL -- requirements
Module: lpm_fifo_dc_flagctl

Interface
REQ-001 SHALL have parameter lpm_widthad, default 4: width of usedw_in.
REQ-002 SHALL have parameter lpm_numwords, default 16: FIFO depth in words.
REQ-003 SHALL have parameter lpm_mode, default "READ": flag-generation side, "READ" or "WRITE".
REQ-004 SHALL have parameters underflow_checking and overflow_checking, each default "ON": "ON" gates requests with flags, "OFF" passes requests through ungated.
REQ-005 SHALL have parameter full_margin, default 3: full asserts at usedw_in >= lpm_numwords-full_margin, floored at 0.
REQ-006 SHALL have parameter almost_full_value, default 12: almost_full threshold.
REQ-007 SHALL have parameter almost_empty_value, default 4: almost_empty threshold.
REQ-008 SHALL have ports: clock  input  1  flag clock; aclr  input  1  asynchronous active-high reset.
REQ-009 SHALL have ports: usedw_in  input  lpm_widthad  word count as seen on this clock domain; wreq  input  1  write request; rreq  input  1  read request.
REQ-010 SHALL have ports: empty, full, almost_empty, almost_full  output  1  registered status flags.
REQ-011 SHALL have ports: valid_rreq, valid_wreq  output  1  gated requests, combinational.
REQ-012 SHALL have ports: underflow, overflow  output  1  sticky error flags.

Function
REQ-013 valid_rreq SHALL equal rreq & !empty when underflow_checking="ON", else rreq; valid_wreq likewise SHALL equal wreq & !full per overflow_checking.
REQ-014 lrreq SHALL be valid_rreq registered by one clock.
REQ-015 In READ mode the state machine SHALL use three states:
- EMPTY -> NON_EMPTY when usedw_in != 0.
- NON_EMPTY -> EMPTY_WAIT when rreq & ((usedw_in==1 & !lrreq) | (usedw_in==2 & lrreq)).
- EMPTY_WAIT -> NON_EMPTY when usedw_in > 1, else -> EMPTY.
REQ-016 In WRITE mode the state machine SHALL use three states:
- EMPTY -> ONE on wreq.
- ONE -> NON_EMPTY on !wreq.
- NON_EMPTY -> ONE on wreq, else -> EMPTY when usedw_in==0.
REQ-017 empty SHALL be registered and SHALL be 1 exactly when the next state is EMPTY or EMPTY_WAIT, i.e. it updates in the same clock edge as the state.
REQ-018 full SHALL be registered as (usedw_in >= lpm_numwords-full_margin), floored at 0, and SHALL update on every clock edge with one cycle of latency.
REQ-019 almost_full SHALL be registered as (usedw_in >= almost_full_value).
REQ-020 almost_empty SHALL be registered as (usedw_in < almost_empty_value).
REQ-021 All threshold comparisons SHALL zero-extend usedw_in to 32 bits; thresholds larger than lpm_numwords SHALL leave the flag permanently deasserted (or permanently asserted for almost_empty) without error.
REQ-022 overflow SHALL set on a clock edge where wreq & full, and SHALL hold until aclr.
REQ-023 underflow SHALL set on a clock edge where rreq & empty, and SHALL hold until aclr.
REQ-024 Both error flags SHALL set regardless of the checking parameters.
REQ-025 When wreq and rreq are asserted in the same cycle, each SHALL be evaluated independently; the state machine SHALL use only the inputs listed in REQ-015/016.
REQ-026 An illegal lpm_mode, checking value, or almost_empty_value > almost_full_value SHALL produce a simulation error message at time 0.

Reset
REQ-027 On aclr assertion, asynchronously: state=EMPTY, lrreq=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-028 full and almost_full SHALL be held at 0 while aclr is high.
REQ-029 The first flag update SHALL occur on the first clock edge after aclr deasserts.

Structure
REQ-030 A shared package SHALL hold the state encodings (EMPTY=00, NON_EMPTY/ONE=01, EMPTY_WAIT=10, NON_EMPTY_W=11) and the mode string constants.
REQ-031 The empty-state machine SHALL be one sub-module, lpm_fifo_dc_emptysm, instantiated once; threshold and sticky logic SHALL stay in the top level.

Verification
REQ-032 READ mode, aclr pulse, then usedw_in=0 for 3 clocks -> empty=1, full=0, almost_empty=1, valid_rreq=0 with rreq=1, underflow=1 after the first edge with rreq=1.
REQ-033 READ mode, usedw_in 0->1, rreq=1 at usedw_in=1 -> empty falls 1 edge after usedw_in=1, rises at the rreq edge, EMPTY_WAIT then EMPTY on usedw_in=0.
REQ-034 WRITE mode, wreq pulses at cycles 1 and 3, usedw_in=0 at cycle 6 -> state sequence EMPTY,ONE,NON_EMPTY,ONE,NON_EMPTY,...,EMPTY; empty=0 from the first wreq edge.
REQ-035 usedw_in ramped 0..15 with numwords=16 -> almost_empty deasserts at 4, almost_full asserts at 12, full asserts at 13, each 1 clock late.
REQ-036 full=1 with wreq=1 and overflow_checking="ON" -> valid_wreq=0, overflow=1 sticky; aclr mid-stream -> all flags return to reset values asynchronously.
